shiftadd_mult: RTL

Sequential unsigned shift-and-add multiplier that drives the team's parameterised ripple adder `addergen_st`, which it instantiates as its datapath.
- Each cycle it presents the partial-product accumulator and a gated multiplicand to the adder, then captures the sum and carry-out.
- An NBITS×NBITS product completes in NBITS iterations.
- It sits between operand sources and downstream consumers that need a full 2·NBITS-bit product without a combinational array multiplier.

---
 rtl/mult_pkg.sv | 17 +
 rtl/addergen_st.sv | 25 ++
 rtl/shiftadd_mult.sv | 112 +++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM state encoding
// and the iteration-counter width helper.
package mult_pkg;

    // 2'b11 is unused and steers back to S_IDLE in the next-state logic.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_e;

    // The counter must be able to hold the values 0 through nbits.
    function automatic int cnt_width(input int nbits);
        return $clog2(nbits + 1);
    endfunction

endpackage

// File: rtl/addergen_st.sv
// Parameterised ripple-carry adder. It forms the datapath of one
// shift-and-add iteration.
module addergen_st #(
    parameter int NBITS = 8
) (
    input  logic [NBITS-1:0] a_i,
    input  logic [NBITS-1:0] b_i,
    input  logic             cin_i,
    output logic [NBITS-1:0] sum_o,
    output logic             cout_o
);

    logic [NBITS:0] carry;

    assign carry[0] = cin_i;

    // One full-adder cell per bit, with the carry rippling upward.
    for (genvar i = 0; i < NBITS; i++) begin : g_bit
        assign sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
        assign carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end

    assign cout_o = carry[NBITS];

endmodule

// File: rtl/shiftadd_mult.sv
// Sequential unsigned shift-and-add multiplier. It performs one add/shift
// iteration per clock and produces a 2*NBITS-bit product after NBITS
// iterations.
module shiftadd_mult
    import mult_pkg::*;
#(
    parameter int NBITS = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [NBITS-1:0]   a,
    input  logic [NBITS-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*NBITS-1:0] p
);

    localparam int            CW       = cnt_width(NBITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(NBITS - 1);

    state_e               state_q, state_d;
    logic [NBITS-1:0]     mcand_q, mcand_d;
    logic [NBITS-1:0]     acc_q,   acc_d;
    logic [NBITS-1:0]     q_q,     q_d;
    logic [CW-1:0]        cnt_q,   cnt_d;
    logic [2*NBITS-1:0]   p_q,     p_d;

    logic [NBITS-1:0]     add_b;
    logic [NBITS-1:0]     add_sum;
    logic                 add_cout;
    logic [2*NBITS-1:0]   iter_res;
    logic                 accept;

    // The multiplicand is added only when the current multiplier LSB is set.
    assign add_b = q_q[0] ? mcand_q : '0;

    addergen_st #(.NBITS(NBITS)) u_adder (
        .a_i    (acc_q),
        .b_i    (add_b),
        .cin_i  (1'b0),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    // The carry-out becomes the new accumulator MSB, so it is kept.
    assign iter_res = {add_cout, add_sum, q_q[NBITS-1:1]};

    // Next-state logic: FSM sequencing, operand load, and a single iteration.
    always_comb begin
        // NOTE: every signal gets a default first, so no path leaves a latch.
        state_d = state_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        accept  = 1'b0;

        case (state_q)
            S_IDLE: accept = start;
            S_RUN: begin
                {acc_d, q_d} = iter_res;
                cnt_d        = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    p_d     = iter_res;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                accept  = start;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A request in IDLE or DONE loads fresh operands; it takes priority
        // over the default DONE -> IDLE return.
        if (accept) begin
            mcand_d = a;
            q_d     = b;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = S_RUN;
        end
    end

    // State and datapath registers, with a synchronous active-low clear.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments, so every register samples pre-edge values.
        if (!rst_n) begin
            state_q <= S_IDLE;
            mcand_q <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign p    = p_q;

endmodule
